// File: rtl/i2c_ov7670_cfg_sequencer_if.sv
// Request/response handshake between the OV7670 config sequencer and the SCCB/I2C byte engine.
// The sequencer holds req with stable addr/wdata/rw until the engine pulses done.
interface i2c_ov7670_cfg_sequencer_if;
  logic       req;
  logic       rw;
  logic [7:0] addr;
  logic [7:0] wdata;
  logic       done;
  logic       nack;
  logic [7:0] rdata;

  modport master (
    output req, rw, addr, wdata,
    input  done, nack, rdata
  );

  modport slave (
    input  req, rw, addr, wdata,
    output done, nack, rdata
  );
endinterface

// File: rtl/i2c_ov7670_cfg_sequencer.sv
// Walks the OV7670 config LUT, issuing one I2C transaction per entry: leading ID reads, then writes.
// Handles NACK retries, the post-soft-reset settle delay and the power-up delay; flags done/error.
module i2c_ov7670_cfg_sequencer #(
  parameter int LUT_SIZE  = 167,
  parameter int READ_NUM  = 2,
  parameter int PWR_DLY   = 100000,
  parameter int SWRST_DLY = 50000,
  parameter int MAX_RETRY = 3,
  parameter int DLY_W     = 20
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               cfg_restart,
  output logic [7:0]                         lut_index,
  input  logic [15:0]                        lut_data,
  i2c_ov7670_cfg_sequencer_if.master         i2c,
  output logic                               id_ok,
  output logic                               cfg_done,
  output logic                               cfg_err,
  output logic [7:0]                         err_index
);

  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [DLY_W-1:0]   PWR_LAST   = DLY_W'(PWR_DLY - 1);
  localparam logic [DLY_W-1:0]   SWRST_LAST = DLY_W'(SWRST_DLY - 1);
  localparam logic [7:0]         LAST_IDX   = 8'(LUT_SIZE - 1);
  localparam logic [7:0]         READ_END   = 8'(READ_NUM);
  localparam logic [RETRY_W-1:0] RETRY_MAX  = RETRY_W'(MAX_RETRY);
  localparam logic [7:0]         COM7_ADDR  = 8'h12;

  typedef enum logic [2:0] {
    PWR_WAIT,
    FETCH,
    ISSUE,
    WAIT,
    SWRST,
    NEXT,
    DONE,
    ERR
  } state_t;

  state_t             state;
  logic [DLY_W-1:0]   dly_cnt;
  logic [RETRY_W-1:0] retry;

  // NOTE: all state updates use <= so every branch reads the pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // An asynchronous reset drops req immediately, even mid-transaction.
      state     <= PWR_WAIT;
      dly_cnt   <= '0;
      retry     <= '0;
      lut_index <= '0;
      i2c.req   <= 1'b0;
      i2c.rw    <= 1'b0;
      i2c.addr  <= '0;
      i2c.wdata <= '0;
      id_ok     <= 1'b1;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
      err_index <= '0;
    end else begin
      case (state)
        PWR_WAIT: begin
          if (dly_cnt == PWR_LAST) state <= FETCH;
          else                     dly_cnt <= dly_cnt + 1'b1;
        end

        FETCH: state <= ISSUE;

        ISSUE: begin
          i2c.addr  <= lut_data[15:8];
          i2c.wdata <= lut_data[7:0];
          i2c.rw    <= (lut_index < READ_END);
          i2c.req   <= 1'b1;
          state     <= WAIT;
        end

        WAIT: begin
          if (i2c.done && i2c.req) begin
            i2c.req <= 1'b0;
            if (i2c.nack) begin
              if (retry == RETRY_MAX) begin
                state     <= ERR;
                cfg_err   <= 1'b1;
                err_index <= lut_index;
              end else begin
                retry <= retry + 1'b1;
                state <= FETCH;
              end
            end else begin
              retry <= '0;
              if (i2c.rw) begin
                // An ID mismatch is reported but does not stop the sequence.
                if (i2c.rdata != lut_data[7:0]) id_ok <= 1'b0;
                state <= NEXT;
              end else if (i2c.addr == COM7_ADDR && i2c.wdata[7]) begin
                dly_cnt <= '0;
                state   <= SWRST;
              end else begin
                state <= NEXT;
              end
            end
          end
        end

        SWRST: begin
          if (dly_cnt == SWRST_LAST) state <= NEXT;
          else                       dly_cnt <= dly_cnt + 1'b1;
        end

        NEXT: begin
          if (lut_index == LAST_IDX) begin
            cfg_done <= 1'b1;
            state    <= DONE;
          end else begin
            lut_index <= lut_index + 1'b1;
            state     <= FETCH;
          end
        end

        DONE, ERR: begin
          if (cfg_restart) begin
            cfg_done  <= 1'b0;
            cfg_err   <= 1'b0;
            err_index <= '0;
            lut_index <= '0;
            retry     <= '0;
            id_ok     <= 1'b1;
            dly_cnt   <= '0;
            state     <= PWR_WAIT;
          end
        end

        default: state <= PWR_WAIT;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_ov7670_cfg_sequencer.sv
// Directed bench for i2c_ov7670_cfg_sequencer: a small LUT, a scripted I2C engine responder
// and hand-computed request timing for power-up, soft-reset, retry, error, restart and reset cases.
module tb_i2c_ov7670_cfg_sequencer;

  localparam int LUT_SIZE  = 10;
  localparam int READ_NUM  = 2;
  localparam int PWR_DLY   = 16;
  localparam int SWRST_DLY = 40;
  localparam int MAX_RETRY = 3;
  localparam int DLY_W     = 20;
  localparam int LOG_MAX   = 64;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_restart = 1'b0;
  logic [7:0]  lut_index;
  logic [15:0] lut_data;
  logic        id_ok, cfg_done, cfg_err;
  logic [7:0]  err_index;

  i2c_ov7670_cfg_sequencer_if i2c ();

  i2c_ov7670_cfg_sequencer #(
    .LUT_SIZE (LUT_SIZE),
    .READ_NUM (READ_NUM),
    .PWR_DLY  (PWR_DLY),
    .SWRST_DLY(SWRST_DLY),
    .MAX_RETRY(MAX_RETRY),
    .DLY_W    (DLY_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .cfg_restart(cfg_restart),
    .lut_index  (lut_index),
    .lut_data   (lut_data),
    .i2c        (i2c),
    .id_ok      (id_ok),
    .cfg_done   (cfg_done),
    .cfg_err    (cfg_err),
    .err_index  (err_index)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] lut_fn(input logic [7:0] idx);
    case (idx)
      8'd0:    lut_fn = 16'h1C7F;
      8'd1:    lut_fn = 16'h1DA2;
      8'd2:    lut_fn = 16'h1280;
      8'd3:    lut_fn = 16'h1200;
      8'd4:    lut_fn = 16'h1101;
      8'd5:    lut_fn = 16'h0C04;
      8'd6:    lut_fn = 16'h3E19;
      8'd7:    lut_fn = 16'h703A;
      8'd8:    lut_fn = 16'h7135;
      8'd9:    lut_fn = 16'h7211;
      default: lut_fn = 16'hDEAD;
    endcase
  endfunction

  assign lut_data = lut_fn(lut_index);

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Request log filled by the engine responder.
  int         req_cnt = 0;
  int         log_cyc   [LOG_MAX];
  logic [7:0] log_idx   [LOG_MAX];
  logic [7:0] log_addr  [LOG_MAX];
  logic [7:0] log_wdata [LOG_MAX];
  logic       log_rw    [LOG_MAX];

  int         nack_idx  = -1;
  int         nack_left = 0;
  logic [7:0] rd_val [2];
  int         r_idx;
  bit         r_nack;

  initial begin
    rd_val[0] = 8'h7F;
    rd_val[1] = 8'hA2;
    i2c.done  = 1'b0;
    i2c.nack  = 1'b0;
    i2c.rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst && i2c.req) begin
        r_idx = int'(lut_index);
        if (req_cnt < LOG_MAX) begin
          log_cyc[req_cnt]   = cyc;
          log_idx[req_cnt]   = lut_index;
          log_addr[req_cnt]  = i2c.addr;
          log_wdata[req_cnt] = i2c.wdata;
          log_rw[req_cnt]    = i2c.rw;
        end
        req_cnt++;
        r_nack = (r_idx == nack_idx) && (nack_left > 0);
        if (r_nack) nack_left--;
        repeat (2) @(negedge clk);
        i2c.done  = 1'b1;
        i2c.nack  = r_nack;
        i2c.rdata = (r_idx < 2) ? rd_val[r_idx] : 8'h00;
        @(negedge clk);
        i2c.done  = 1'b0;
        i2c.nack  = 1'b0;
      end
    end
  end

  int rel_cyc = 0;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (5) @(negedge clk);
    req_cnt = 0;
    rst     = 1'b0;
    rel_cyc = cyc;
  endtask

  task automatic wait_end(input string tag);
    bit seen = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (cfg_done || cfg_err) begin
        seen = 1'b1;
        break;
      end
    end
    check({tag, "_finish_timeout"}, 32'(seen), 32'd1);
  endtask

  task automatic check_full_log(input string tag);
    logic [15:0] e;
    check({tag, "_req_count"}, 32'(req_cnt), 32'(LUT_SIZE));
    for (int i = 0; i < LUT_SIZE && i < req_cnt; i++) begin
      e = lut_fn(8'(i));
      check($sformatf("%s_idx%0d", tag, i),   32'(log_idx[i]),   32'(i));
      check($sformatf("%s_addr%0d", tag, i),  32'(log_addr[i]),  32'(e[15:8]));
      check($sformatf("%s_wdata%0d", tag, i), 32'(log_wdata[i]), 32'(e[7:0]));
      check($sformatf("%s_rw%0d", tag, i),    32'(log_rw[i]),    32'(i < READ_NUM));
    end
  endtask

  int cnt5;
  int rs_cyc;
  bit got_req;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req",       32'(i2c.req),   32'd0);
    check("rst_lut_index", 32'(lut_index), 32'd0);
    check("rst_id_ok",     32'(id_ok),     32'd1);
    check("rst_cfg_done",  32'(cfg_done),  32'd0);
    check("rst_cfg_err",   32'(cfg_err),   32'd0);
    check("rst_err_index", 32'(err_index), 32'd0);

    // T1/T2/T3: clean run
    do_reset();
    wait_end("t2");
    check("t1_first_req_latency", 32'(log_cyc[0] - rel_cyc), 32'd18);
    check("t1_id_ok", 32'(id_ok), 32'd1);
    check_full_log("t2");
    check("t2_cfg_done", 32'(cfg_done), 32'd1);
    check("t2_cfg_err",  32'(cfg_err),  32'd0);
    check("t3_swrst_gap",  32'(log_cyc[3] - log_cyc[2]), 32'(6 + SWRST_DLY));
    check("t3_plain_gap",  32'(log_cyc[4] - log_cyc[3]), 32'd6);

    // T4a: two NACKs at index 5, then ack
    nack_idx  = 5;
    nack_left = 2;
    do_reset();
    wait_end("t4a");
    cnt5 = 0;
    for (int i = 0; i < req_cnt && i < LOG_MAX; i++) if (log_idx[i] == 8'd5) cnt5++;
    check("t4a_idx5_reqs",  32'(cnt5),     32'd3);
    check("t4a_req_count",  32'(req_cnt),  32'(LUT_SIZE + 2));
    check("t4a_cfg_done",   32'(cfg_done), 32'd1);
    check("t4a_cfg_err",    32'(cfg_err),  32'd0);

    // T4b: retries exhausted at index 5
    nack_left = 4;
    do_reset();
    wait_end("t4b");
    check("t4b_cfg_err",   32'(cfg_err),   32'd1);
    check("t4b_err_index", 32'(err_index), 32'd5);
    check("t4b_cfg_done",  32'(cfg_done),  32'd0);
    repeat (60) @(negedge clk);
    check("t4b_req_count", 32'(req_cnt), 32'd9);
    check("t4b_req_low",   32'(i2c.req), 32'd0);
    nack_idx  = -1;
    nack_left = 0;

    // T5: ID mismatch, then restart from DONE
    rd_val[0] = 8'h00;
    do_reset();
    wait_end("t5a");
    check("t5_id_ok_cleared", 32'(id_ok),    32'd0);
    check("t5_done_anyway",   32'(cfg_done), 32'd1);
    check("t5_count",         32'(req_cnt),  32'(LUT_SIZE));
    rd_val[0] = 8'h7F;
    cfg_restart = 1'b1;
    rs_cyc  = cyc;
    req_cnt = 0;
    @(negedge clk);
    cfg_restart = 1'b0;
    check("t5_restart_id_ok",    32'(id_ok),     32'd1);
    check("t5_restart_cfg_done", 32'(cfg_done),  32'd0);
    check("t5_restart_index",    32'(lut_index), 32'd0);
    wait_end("t5b");
    check("t5_rerun_latency", 32'(log_cyc[0] - rs_cyc), 32'd19);
    check("t5_rerun_count",   32'(req_cnt),  32'(LUT_SIZE));
    check("t5_rerun_id_ok",   32'(id_ok),    32'd1);
    check("t5_rerun_done",    32'(cfg_done), 32'd1);

    // T6: reset while a transaction is outstanding
    do_reset();
    got_req = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i2c.req) begin
        got_req = 1'b1;
        break;
      end
    end
    check("t6_saw_req", 32'(got_req), 32'd1);
    rst = 1'b1;
    #1;
    check("t6_req_async_drop", 32'(i2c.req), 32'd0);
    @(posedge clk);
    #1;
    check("t6_req_after_edge", 32'(i2c.req), 32'd0);
    repeat (5) @(negedge clk);
    req_cnt = 0;
    rst     = 1'b0;
    rel_cyc = cyc;
    wait_end("t6");
    check("t6_latency",   32'(log_cyc[0] - rel_cyc), 32'd18);
    check("t6_first_idx", 32'(log_idx[0]), 32'd0);
    check("t6_count",     32'(req_cnt),    32'(LUT_SIZE));
    check("t6_cfg_done",  32'(cfg_done),   32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
